// File: rtl/calc_dec_disp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_dec_disp: opcode-to-button decoder with 4-digit seven-seg readback  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_dec_disp #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             btnu,
    input  logic [3:0]       alu_op,
    input  logic             op_valid,
    output logic [2:0]       btn_dec,
    output logic             dec_valid,
    output logic             op_illegal,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int unsigned c_SCAN_W   = 20;
    localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(REFRESH_DIV - 1);

    localparam logic [6:0] c_GLYPH_L     = 7'b1000111;
    localparam logic [6:0] c_GLYPH_C     = 7'b1000110;
    localparam logic [6:0] c_GLYPH_R     = 7'b0101111;
    localparam logic [6:0] c_GLYPH_E     = 7'b0000110;
    localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;

    logic [3:0]          r_op_q;
    logic [2:0]          r_btn_dec;
    logic                r_dec_valid;
    logic                r_op_illegal;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [c_SCAN_W-1:0] r_scan;
    logic [1:0]          r_idx;

    logic [2:0]          w_btn;
    logic                w_illegal;

    function automatic logic [6:0] f_hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: f_hex_glyph = 7'b1000000;
            4'h1: f_hex_glyph = 7'b1111001;
            4'h2: f_hex_glyph = 7'b0100100;
            4'h3: f_hex_glyph = 7'b0110000;
            4'h4: f_hex_glyph = 7'b0011001;
            4'h5: f_hex_glyph = 7'b0010010;
            4'h6: f_hex_glyph = 7'b0000010;
            4'h7: f_hex_glyph = 7'b1111000;
            4'h8: f_hex_glyph = 7'b0000000;
            4'h9: f_hex_glyph = 7'b0010000;
            4'hA: f_hex_glyph = 7'b0001000;
            4'hB: f_hex_glyph = 7'b0000011;
            4'hC: f_hex_glyph = 7'b1000110;
            4'hD: f_hex_glyph = 7'b0100001;
            4'hE: f_hex_glyph = 7'b0000110;
            default: f_hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Inverse of the button-to-opcode encoder; unreachable codes decode to 000.
    always_comb begin
        w_btn     = 3'b000;
        w_illegal = 1'b0;
        case (alu_op)
            4'b0000: w_btn = 3'b000;
            4'b0001: w_btn = 3'b001;
            4'b0010: w_btn = 3'b010;
            4'b0110: w_btn = 3'b011;
            4'b0100: w_btn = 3'b100;
            4'b1001: w_btn = 3'b101;
            4'b1010: w_btn = 3'b110;
            4'b0101: w_btn = 3'b111;
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            r_op_q       <= 4'b0000;
            r_btn_dec    <= 3'b000;
            r_dec_valid  <= 1'b0;
            r_op_illegal <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_dec_valid <= op_valid;
            if (op_valid) begin
                r_op_q       <= alu_op;
                r_btn_dec    <= w_btn;
                r_op_illegal <= w_illegal;
                if (w_illegal && (r_err_cnt != {ERR_W{1'b1}}))
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
        end else if (r_scan == c_SCAN_MAX) begin
            r_scan <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_scan <= r_scan + c_SCAN_W'(1);
        end
    end

    // Digit mux: anodes depend only on r_idx, so they are stable between wraps.
    always_comb begin
        an  = 4'b1111;
        seg = c_GLYPH_BLANK;
        case (r_idx)
            2'd0: begin
                an  = 4'b1110;
                seg = f_hex_glyph(r_op_q);
            end
            2'd1: begin
                an  = 4'b1101;
                seg = r_op_illegal ? c_GLYPH_E : (r_btn_dec[0] ? c_GLYPH_R : c_GLYPH_BLANK);
            end
            2'd2: begin
                an  = 4'b1011;
                seg = r_op_illegal ? c_GLYPH_E : (r_btn_dec[1] ? c_GLYPH_C : c_GLYPH_BLANK);
            end
            default: begin
                an  = 4'b0111;
                seg = r_op_illegal ? c_GLYPH_E : (r_btn_dec[2] ? c_GLYPH_L : c_GLYPH_BLANK);
            end
        endcase
    end

    assign btn_dec    = r_btn_dec;
    assign dec_valid  = r_dec_valid;
    assign op_illegal = r_op_illegal;
    assign err_cnt    = r_err_cnt;
    assign dp         = 1'b1;

endmodule
`default_nettype wire
